// File: rtl/id_token_stats.sv
// Digit-run statistics for identifier tokens: measures each run of match=1
// samples, pulses on run completion and keeps count / longest-run statistics.
module id_token_stats #(
    parameter int unsigned LEN_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             match,
    input  logic             clr,
    output logic             tok_done,
    output logic [LEN_W-1:0] tok_len,
    output logic [CNT_W-1:0] tok_count,
    output logic [LEN_W-1:0] max_len,
    output logic             cnt_sat,
    output logic             busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]       r_state;
    logic [LEN_W-1:0] r_run;
    logic             r_tok_done;
    logic [LEN_W-1:0] r_tok_len;
    logic [CNT_W-1:0] r_tok_count;
    logic [LEN_W-1:0] r_max_len;
    logic             r_cnt_sat;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_state     <= S_IDLE;
            r_run       <= '0;
            r_tok_done  <= 1'b0;
            r_tok_len   <= '0;
            r_tok_count <= '0;
            r_max_len   <= '0;
            r_cnt_sat   <= 1'b0;
        end else begin
            r_tok_done <= 1'b0;
            // match is ignored entirely while en=0, so an X there cannot leak into state
            if (en) begin
                case (r_state)
                    S_IDLE: begin
                        if (match) begin
                            r_state <= S_RUN;
                            r_run   <= LEN_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (match) begin
                            if (r_run != LEN_MAX)
                                r_run <= r_run + LEN_W'(1);
                        end else begin
                            r_state    <= S_IDLE;
                            r_tok_done <= 1'b1;
                            r_tok_len  <= r_run;
                            if (r_run > r_max_len)
                                r_max_len <= r_run;
                            if (r_tok_count != CNT_MAX) begin
                                r_tok_count <= r_tok_count + CNT_W'(1);
                                if (r_tok_count == CNT_MAX - CNT_W'(1))
                                    r_cnt_sat <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign tok_done  = r_tok_done;
    assign tok_len   = r_tok_len;
    assign tok_count = r_tok_count;
    assign max_len   = r_max_len;
    assign cnt_sat   = r_cnt_sat;
    assign busy      = (r_state == S_RUN);

endmodule

// File: tb/tb_id_token_stats.sv
// Randomized + directed bench for id_token_stats: a default instance and a
// narrow instance (LEN_W=3, CNT_W=4) share stimulus and are checked against a run-length model.
module tb_id_token_stats;

    logic clk = 1'b0;
    logic rst_n, en, match, clr;

    logic       d0_done, d0_sat, d0_busy;
    logic [7:0] d0_len, d0_max;
    logic [15:0] d0_cnt;
    logic       d1_done, d1_sat, d1_busy;
    logic [2:0] d1_len, d1_max;
    logic [3:0] d1_cnt;

    id_token_stats dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .match(match), .clr(clr),
        .tok_done(d0_done), .tok_len(d0_len), .tok_count(d0_cnt),
        .max_len(d0_max), .cnt_sat(d0_sat), .busy(d0_busy)
    );

    id_token_stats #(.LEN_W(3), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .match(match), .clr(clr),
        .tok_done(d1_done), .tok_len(d1_len), .tok_count(d1_cnt),
        .max_len(d1_max), .cnt_sat(d1_sat), .busy(d1_busy)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    longint unsigned LMAX [2] = '{255, 7};
    longint unsigned CMAX [2] = '{65535, 15};

    // Model: unbounded run length, clamped only when it is reported.
    bit              m_in_run [2];
    longint unsigned m_len    [2];
    bit              m_done   [2];
    longint unsigned m_last   [2];
    longint unsigned m_cnt    [2];
    longint unsigned m_max    [2];
    bit              m_sat    [2];

    task automatic check_val(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        if (!rst_n || clr) begin
            m_in_run[i] = 0; m_len[i] = 0; m_done[i] = 0; m_last[i] = 0;
            m_cnt[i] = 0; m_max[i] = 0; m_sat[i] = 0;
        end else begin
            m_done[i] = 0;
            if (en) begin
                if (!m_in_run[i]) begin
                    if (match) begin m_in_run[i] = 1; m_len[i] = 1; end
                end else if (match) begin
                    m_len[i]++;
                end else begin
                    m_in_run[i] = 0;
                    m_done[i] = 1;
                    m_last[i] = (m_len[i] < LMAX[i]) ? m_len[i] : LMAX[i];
                    if (m_last[i] > m_max[i]) m_max[i] = m_last[i];
                    m_cnt[i] = (m_cnt[i] + 1 < CMAX[i]) ? m_cnt[i] + 1 : CMAX[i];
                    if (m_cnt[i] == CMAX[i]) m_sat[i] = 1;
                end
            end
        end
    endtask

    task automatic check_all();
        check_val("d0.tok_done", d0_done, m_done[0]);
        check_val("d0.tok_len", d0_len, m_last[0]);
        check_val("d0.tok_count", d0_cnt, m_cnt[0]);
        check_val("d0.max_len", d0_max, m_max[0]);
        check_val("d0.cnt_sat", d0_sat, m_sat[0]);
        check_val("d0.busy", d0_busy, m_in_run[0]);
        check_val("d1.tok_done", d1_done, m_done[1]);
        check_val("d1.tok_len", d1_len, m_last[1]);
        check_val("d1.tok_count", d1_cnt, m_cnt[1]);
        check_val("d1.max_len", d1_max, m_max[1]);
        check_val("d1.cnt_sat", d1_sat, m_sat[1]);
        check_val("d1.busy", d1_busy, m_in_run[1]);
    endtask

    task automatic cycle(input bit r, input bit e, input bit m, input bit c);
        rst_n = r; en = e; match = m; clr = c;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic go(input bit m);
        cycle(1, 1, m, 0);
    endtask

    initial begin
        rst_n = 0; en = 0; match = 0; clr = 0;
        cycle(0, 0, 0, 0);
        cycle(0, 1, 1, 1);
        check_val("reset.tok_count", d0_cnt, 0);
        check_val("reset.busy", d0_busy, 0);

        // 0,1,1,1,0 -> len 3
        go(0); go(1); go(1); go(1); go(0);
        check_val("seq3.tok_done", d0_done, 1);
        check_val("seq3.tok_len", d0_len, 3);
        check_val("seq3.tok_count", d0_cnt, 1);
        check_val("seq3.max_len", d0_max, 3);
        go(0);
        check_val("seq3.pulse_once", d0_done, 0);

        // runs 2,5,1
        cycle(1, 1, 0, 1);
        go(1); go(1); go(0);
        check_val("r251.len2", d0_len, 2);
        for (int k = 0; k < 5; k++) go(1);
        go(0);
        check_val("r251.len5", d0_len, 5);
        go(1); go(0);
        check_val("r251.len1", d0_len, 1);
        check_val("r251.count", d0_cnt, 3);
        check_val("r251.max", d0_max, 5);

        // 300-long run saturates both run counters
        for (int k = 0; k < 300; k++) begin
            go(1);
            check_val("long.busy", d0_busy, 1);
        end
        go(0);
        check_val("long.tok_len", d0_len, 255);
        check_val("long.max_len", d0_max, 255);
        check_val("long.d1_len", d1_len, 7);

        // en=0 freeze mid-run
        cycle(1, 1, 0, 1);
        go(1); go(1);
        for (int k = 0; k < 4; k++) begin
            cycle(1, 0, k[0], 0);
            check_val("freeze.no_pulse", d0_done, 0);
        end
        go(1); go(0);
        check_val("freeze.tok_len", d0_len, 3);
        check_val("freeze.count", d0_cnt, 1);

        // clr coincident with terminating 0
        cycle(1, 1, 0, 1);
        go(1); go(1);
        cycle(1, 1, 0, 1);
        check_val("clrterm.done", d0_done, 0);
        check_val("clrterm.count", d0_cnt, 0);
        check_val("clrterm.busy", d0_busy, 0);

        // 16 runs on the narrow counter
        for (int k = 0; k < 16; k++) begin go(1); go(0); end
        check_val("sat.d1_count", d1_cnt, 15);
        check_val("sat.d1_sat", d1_sat, 1);
        check_val("sat.d1_done", d1_done, 1);

        // reset mid-run of 4
        cycle(1, 1, 0, 1);
        for (int k = 0; k < 4; k++) go(1);
        cycle(0, 1, 1, 0);
        check_val("rstmid.busy", d0_busy, 0);
        check_val("rstmid.done", d0_done, 0);
        go(1); go(0);
        check_val("rstmid.count", d0_cnt, 1);
        check_val("rstmid.len", d0_len, 1);

        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
